// File: rtl/digit_conv_pkg.sv
// Shared constants, FSM state type and ASCII helper for the digit converter.
package digit_conv_pkg;

    localparam logic [7:0] ASCII_ZERO    = 8'h30;
    localparam logic [7:0] ASCII_SPACE   = 8'h20;
    localparam logic [6:0] MAX_TWO_DIGIT = 7'd99;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        DONE
    } state_t;

    // Map a single decimal digit (0..9) to its ASCII character.
    function automatic logic [7:0] ascii_digit(input logic [3:0] d);
        return ASCII_ZERO + {4'b0000, d};
    endfunction

endpackage

// File: rtl/digit_conv_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
// The caller registers the result and advances ptr.
module rr_arbiter #(
    parameter int N_REQ = 3
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] idx,
    output logic                     any
);

    localparam int IW = $clog2(N_REQ);

    logic          found;
    logic [IW-1:0] cand;

    // Walk the requesters in priority order starting at ptr; the first hit wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = IW'((int'(ptr) + k) % N_REQ);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/digit_conv_arbiter.sv
// Shared two-digit integer-to-ASCII converter with round-robin arbitration.
// Conversion is repeated subtraction by 10; values above 99 saturate to "99".
// Build option: define DIGIT_CONV_BLANK_EN to print a space instead of a
// leading zero in the tens position.
module digit_conv_arbiter
    import digit_conv_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int VAL_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*VAL_W-1:0]   value,
    output logic [N_REQ-1:0]         gnt,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(N_REQ)-1:0] done_id,
    output logic [7:0]               msd_ascii,
    output logic [7:0]               lsd_ascii
);

    localparam int IW = $clog2(N_REQ);

    state_t        state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] id;
    logic [6:0]    rem;
    logic [3:0]    tens;

    logic [N_REQ-1:0] arb_gnt;
    logic [IW-1:0]    arb_idx;
    logic             arb_any;
    logic [VAL_W-1:0] gval;
    logic [6:0]       clamped;
    logic [IW-1:0]    next_ptr;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req   (req),
        .ptr   (ptr),
        .grant (arb_gnt),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    // Winner's value, saturated to two digits, and the pointer past the winner.
    always_comb begin
        gval     = value[int'(arb_idx)*VAL_W +: VAL_W];
        clamped  = (32'(gval) > 32'(MAX_TWO_DIGIT)) ? MAX_TWO_DIGIT : 7'(gval);
        next_ptr = (int'(arb_idx) == N_REQ - 1) ? '0 : arb_idx + 1'b1;
    end

    // Control FSM: grant in IDLE, divide in DIV, publish result on entry to DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            id        <= '0;
            rem       <= '0;
            tens      <= '0;
            gnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            done_id   <= '0;
            msd_ascii <= ASCII_ZERO;
            lsd_ascii <= ASCII_ZERO;
        end else begin
            gnt  <= '0;
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (arb_any) begin
                        state <= DIV;
                        gnt   <= arb_gnt;
                        busy  <= 1'b1;
                        id    <= arb_idx;
                        rem   <= clamped;
                        tens  <= '0;
                        ptr   <= next_ptr;
                    end
                end
                DIV: begin
                    if (rem >= 7'd10) begin
                        rem  <= rem - 7'd10;
                        tens <= tens + 4'd1;
                    end else begin
                        state     <= DONE;
                        done      <= 1'b1;
                        done_id   <= id;
                        lsd_ascii <= ascii_digit(rem[3:0]);
`ifdef DIGIT_CONV_BLANK_EN
                        msd_ascii <= (tens == 4'd0) ? ASCII_SPACE : ascii_digit(tens);
`else
                        msd_ascii <= ascii_digit(tens);
`endif
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_digit_conv_arbiter.sv
// Scoreboard bench for digit_conv_arbiter: expected grants and results are
// queued when requests are driven and matched against gnt/done as they occur.
module tb_digit_conv_arbiter;

    localparam int N_REQ = 3;
    localparam int VAL_W = 8;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [N_REQ-1:0]       req = '0;
    logic [N_REQ*VAL_W-1:0] value = '0;
    logic [N_REQ-1:0]       gnt;
    logic                   busy;
    logic                   done;
    logic [1:0]             done_id;
    logic [7:0]             msd_ascii;
    logic [7:0]             lsd_ascii;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        int         id;
        logic [7:0] msd;
        logic [7:0] lsd;
        int         cyc;
    } res_t;

    typedef struct {
        int id;
        int cyc;
    } gexp_t;

    res_t  sb[$];
    gexp_t gq[$];

    digit_conv_arbiter #(.N_REQ(N_REQ), .VAL_W(VAL_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .value     (value),
        .gnt       (gnt),
        .busy      (busy),
        .done      (done),
        .done_id   (done_id),
        .msd_ascii (msd_ascii),
        .lsd_ascii (lsd_ascii)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int clampv(input int v);
        return (v > 99) ? 99 : v;
    endfunction

    function automatic logic [7:0] exp_msd(input int v);
        int t;
        t = clampv(v) / 10;
`ifdef DIGIT_CONV_BLANK_EN
        if (t == 0) return 8'h20;
`endif
        return 8'(8'h30 + t);
    endfunction

    function automatic logic [7:0] exp_lsd(input int v);
        return 8'(8'h30 + clampv(v) % 10);
    endfunction

    // Queue the grant and result for a request seen in IDLE during cycle t.
    task automatic expect_conv(input int id, input int v, input int t);
        gq.push_back('{id: id, cyc: t + 1});
        sb.push_back('{id: id, msd: exp_msd(v), lsd: exp_lsd(v), cyc: t + 2 + clampv(v) / 10});
    endtask

    // Match every grant and every done against the queued expectations.
    always @(negedge clk) begin
        gexp_t g;
        res_t  r;
        if (!rst && gnt !== '0) begin
            if (gq.size() == 0) chk("unexp_gnt", 32'(gnt), 32'd0);
            else begin
                g = gq.pop_front();
                chk("gnt_vec", 32'(gnt), 32'(1) << g.id);
                chk("gnt_cyc", cyc, g.cyc);
            end
        end
        if (!rst && done === 1'b1) begin
            if (sb.size() == 0) chk("unexp_done", 32'(done), 32'd0);
            else begin
                r = sb.pop_front();
                chk("done_id", 32'(done_id), r.id);
                chk("msd", 32'(msd_ascii), 32'(r.msd));
                chk("lsd", 32'(lsd_ascii), 32'(r.lsd));
                chk("done_cyc", cyc, r.cyc);
            end
        end
    end

    task automatic wait_drain(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0 && gq.size() == 0) return;
        end
        chk("drain_timeout", 32'(sb.size() + gq.size()), 32'd0);
        sb.delete();
        gq.delete();
    endtask

    task automatic single(input int id, input int v, input bit scramble);
        int t;
        @(negedge clk);
        t = cyc;
        req[id] = 1'b1;
        value[id*VAL_W +: VAL_W] = VAL_W'(v);
        expect_conv(id, v, t);
        @(negedge clk);
        chk("busy_on", 32'(busy), 32'd1);
        req[id] = 1'b0;
        if (scramble) value[id*VAL_W +: VAL_W] = 8'hFF;
        wait_drain(40);
        @(negedge clk);
        chk("busy_off", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int vals[3];
        vals = '{5, 12, 99};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_done_id", 32'(done_id), 32'd0);
        chk("rst_msd", 32'(msd_ascii), 32'h30);
        chk("rst_lsd", 32'(lsd_ascii), 32'h30);

        // All requesters held high from reset release: strict rotation 0,1,2,...
        req = '1;
        value = {8'd99, 8'd12, 8'd5};
        t = cyc;
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            expect_conv(k % 3, vals[k % 3], t);
            t = t + 3 + clampv(vals[k % 3]) / 10;
        end
        wait_drain(150);
        req = '0;
        repeat (3) @(negedge clk);

        // Single requesters: zero, mid value, saturation, captured-at-grant
        single(0, 0, 1'b0);
        single(1, 47, 1'b0);
        single(2, 200, 1'b0);
        single(0, 35, 1'b1);

        // Reset two cycles into DIV aborts the conversion
        @(negedge clk);
        t = cyc;
        req[1] = 1'b1;
        value[15:8] = 8'd80;
        gq.push_back('{id: 1, cyc: t + 1});
        @(negedge clk);
        req[1] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_gnt", 32'(gnt), 32'd0);
        chk("abort_done_id", 32'(done_id), 32'd0);
        chk("abort_msd", 32'(msd_ascii), 32'h30);
        chk("abort_lsd", 32'(lsd_ascii), 32'h30);
        repeat (15) @(negedge clk);
        chk("abort_gq_empty", 32'(gq.size()), 32'd0);
        gq.delete();

        // Pointer restarts at 0: requesters 1 and 2 pending, 1 goes first
        @(negedge clk);
        t = cyc;
        req = 3'b110;
        value[15:8] = 8'd63;
        value[23:16] = 8'd9;
        expect_conv(1, 63, t);
        expect_conv(2, 9, t + 9);
        @(negedge clk);
        req[1] = 1'b0;
        repeat (9) @(negedge clk);
        req[2] = 1'b0;
        wait_drain(30);

        repeat (4) @(negedge clk);
        chk("final_sb_empty", 32'(sb.size()), 32'd0);
        chk("final_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
